// File: rtl/jelly_fixed_float_mul_add2_arbiter_if.sv
// Requester, result and shared-unit buses of the mul_add2 arbiter.
// The slave modport is the arbiter's view; master is the surrounding system.
interface jelly_fixed_float_mul_add2_arbiter_if #(
    parameter int unsigned NUM                  = 3,
    parameter int unsigned ID_WIDTH             = (NUM > 1) ? $clog2(NUM) : 1,
    parameter int unsigned USER_WIDTH           = 0,
    parameter int unsigned S_FIXED_WIDTH        = 12,
    parameter int unsigned S_FLOAT_WIDTH        = 32,
    parameter int unsigned M_DENORM_EXP_WIDTH   = 8,
    parameter int unsigned M_DENORM_FIXED_WIDTH = 48
);
    localparam int unsigned USER_BITS       = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int unsigned UNIT_USER_WIDTH = ID_WIDTH + USER_BITS;

    logic [NUM*USER_BITS-1:0]            s_user;
    logic [NUM*S_FIXED_WIDTH-1:0]        s_fixed_x;
    logic [NUM*S_FIXED_WIDTH-1:0]        s_fixed_y;
    logic [NUM*S_FLOAT_WIDTH-1:0]        s_float_a;
    logic [NUM*S_FLOAT_WIDTH-1:0]        s_float_b;
    logic [NUM*S_FLOAT_WIDTH-1:0]        s_float_c;
    logic [NUM-1:0]                      s_valid;
    logic [NUM-1:0]                      s_ready;

    logic [NUM*USER_BITS-1:0]            m_user;
    logic [NUM*M_DENORM_EXP_WIDTH-1:0]   m_denorm_exp;
    logic [NUM*M_DENORM_FIXED_WIDTH-1:0] m_denorm_fixed;
    logic [NUM-1:0]                      m_valid;
    logic [NUM-1:0]                      m_ready;

    logic [UNIT_USER_WIDTH-1:0]          unit_s_user;
    logic [S_FIXED_WIDTH-1:0]            unit_s_fixed_x;
    logic [S_FIXED_WIDTH-1:0]            unit_s_fixed_y;
    logic [S_FLOAT_WIDTH-1:0]            unit_s_float_a;
    logic [S_FLOAT_WIDTH-1:0]            unit_s_float_b;
    logic [S_FLOAT_WIDTH-1:0]            unit_s_float_c;
    logic                                unit_s_valid;
    logic                                unit_s_ready;

    logic [UNIT_USER_WIDTH-1:0]          unit_m_user;
    logic [M_DENORM_EXP_WIDTH-1:0]       unit_m_denorm_exp;
    logic [M_DENORM_FIXED_WIDTH-1:0]     unit_m_denorm_fixed;
    logic                                unit_m_valid;
    logic                                unit_m_ready;

    modport slave (
        input  s_user, s_fixed_x, s_fixed_y, s_float_a, s_float_b, s_float_c, s_valid,
        output s_ready,
        output m_user, m_denorm_exp, m_denorm_fixed, m_valid,
        input  m_ready,
        output unit_s_user, unit_s_fixed_x, unit_s_fixed_y,
        output unit_s_float_a, unit_s_float_b, unit_s_float_c, unit_s_valid,
        input  unit_s_ready,
        input  unit_m_user, unit_m_denorm_exp, unit_m_denorm_fixed, unit_m_valid,
        output unit_m_ready
    );

    modport master (
        output s_user, s_fixed_x, s_fixed_y, s_float_a, s_float_b, s_float_c, s_valid,
        input  s_ready,
        input  m_user, m_denorm_exp, m_denorm_fixed, m_valid,
        output m_ready,
        input  unit_s_user, unit_s_fixed_x, unit_s_fixed_y,
        input  unit_s_float_a, unit_s_float_b, unit_s_float_c, unit_s_valid,
        output unit_s_ready,
        output unit_m_user, unit_m_denorm_exp, unit_m_denorm_fixed, unit_m_valid,
        input  unit_m_ready
    );
endinterface

// File: rtl/jelly_fixed_float_mul_add2_arbiter.sv
// Round-robin sharing of one mul_add2 unit between NUM ports; the port index rides
// in the unit user field and steers each result back, with a per-port in-flight cap.
module jelly_fixed_float_mul_add2_arbiter #(
    parameter int unsigned NUM                  = 3,
    parameter int unsigned ID_WIDTH             = (NUM > 1) ? $clog2(NUM) : 1,
    parameter int unsigned USER_WIDTH           = 0,
    parameter int unsigned S_FIXED_WIDTH        = 12,
    parameter int unsigned S_FLOAT_WIDTH        = 32,
    parameter int unsigned M_DENORM_EXP_WIDTH   = 8,
    parameter int unsigned M_DENORM_FIXED_WIDTH = 48,
    parameter int unsigned MAX_OUTSTANDING      = 8
) (
    input  logic                                  clk,
    input  logic                                  reset_n,
    jelly_fixed_float_mul_add2_arbiter_if.slave   bus
);
    localparam int unsigned USER_BITS       = (USER_WIDTH > 0) ? USER_WIDTH : 1;
    localparam int unsigned UNIT_USER_WIDTH = ID_WIDTH + USER_BITS;
    localparam int unsigned CNT_WIDTH       = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic {ST_OPEN, ST_LOCKED} state_t;

    state_t               state;
    logic [ID_WIDTH-1:0]  rr_ptr;
    logic [ID_WIDTH-1:0]  lock_id;
    logic [ID_WIDTH-1:0]  grant;
    logic [ID_WIDTH-1:0]  ret_id;
    logic [CNT_WIDTH-1:0] cnt [NUM];
    logic [NUM-1:0]       elig;
    logic [NUM-1:0]       inc;
    logic [NUM-1:0]       dec;
    logic                 any_elig;
    logic                 issue_valid;
    logic                 issue_hs;
    logic                 id_ok;

    always_comb begin
        for (int unsigned i = 0; i < NUM; i++) begin
            elig[i] = bus.s_valid[i] && (cnt[i] != CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    // First eligible port from rr_ptr upward; a stalled offer stays pinned to lock_id.
    always_comb begin
        int unsigned idx;
        idx      = 0;
        grant    = rr_ptr;
        any_elig = 1'b0;
        for (int unsigned k = 0; k < NUM; k++) begin
            idx = 32'(rr_ptr) + k;
            if (idx >= NUM) idx = idx - NUM;
            if (!any_elig && elig[idx]) begin
                grant    = ID_WIDTH'(idx);
                any_elig = 1'b1;
            end
        end
        if (state == ST_LOCKED) grant = lock_id;
    end

    assign issue_valid        = reset_n && ((state == ST_LOCKED) || any_elig);
    assign issue_hs           = issue_valid && bus.unit_s_ready;
    assign bus.unit_s_valid   = issue_valid;
    assign bus.s_ready        = issue_hs ? (NUM'(1) << grant) : '0;
    assign bus.unit_s_user    = {grant, bus.s_user[32'(grant)*USER_BITS +: USER_BITS]};
    assign bus.unit_s_fixed_x = bus.s_fixed_x[32'(grant)*S_FIXED_WIDTH +: S_FIXED_WIDTH];
    assign bus.unit_s_fixed_y = bus.s_fixed_y[32'(grant)*S_FIXED_WIDTH +: S_FIXED_WIDTH];
    assign bus.unit_s_float_a = bus.s_float_a[32'(grant)*S_FLOAT_WIDTH +: S_FLOAT_WIDTH];
    assign bus.unit_s_float_b = bus.s_float_b[32'(grant)*S_FLOAT_WIDTH +: S_FLOAT_WIDTH];
    assign bus.unit_s_float_c = bus.s_float_c[32'(grant)*S_FLOAT_WIDTH +: S_FLOAT_WIDTH];

    // Out-of-range ids are swallowed so a bad word can never wedge the unit.
    assign ret_id             = bus.unit_m_user[UNIT_USER_WIDTH-1 -: ID_WIDTH];
    assign id_ok              = 32'(ret_id) < NUM;
    assign bus.unit_m_ready   = reset_n && (id_ok ? bus.m_ready[ret_id] : 1'b1);
    assign bus.m_valid        = (reset_n && bus.unit_m_valid && id_ok) ? (NUM'(1) << ret_id) : '0;
    assign bus.m_user         = {NUM{bus.unit_m_user[USER_BITS-1:0]}};
    assign bus.m_denorm_exp   = {NUM{bus.unit_m_denorm_exp}};
    assign bus.m_denorm_fixed = {NUM{bus.unit_m_denorm_fixed}};

    assign inc = bus.s_ready;
    assign dec = bus.m_valid & bus.m_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_OPEN;
            rr_ptr  <= '0;
            lock_id <= '0;
            for (int unsigned i = 0; i < NUM; i++) cnt[i] <= '0;
        end else begin
            if (issue_hs) begin
                state  <= ST_OPEN;
                rr_ptr <= (grant == ID_WIDTH'(NUM - 1)) ? '0 : grant + 1'b1;
            end else if (issue_valid) begin
                state   <= ST_LOCKED;
                lock_id <= grant;
            end
            for (int unsigned i = 0; i < NUM; i++) begin
                if (inc[i] && !dec[i])      cnt[i] <= cnt[i] + 1'b1;
                else if (dec[i] && !inc[i]) cnt[i] <= cnt[i] - 1'b1;
            end
        end
    end

    always @(posedge clk) begin
        if (reset_n) begin
            for (int unsigned i = 0; i < NUM; i++) begin
                assert (!(dec[i] && !inc[i] && cnt[i] == '0))
                    else $error("outstanding count underflow on port %0d", i);
            end
            assert (!(bus.unit_m_valid && !id_ok))
                else $error("returned id %0d out of range, word dropped", ret_id);
        end
    end
endmodule

// File: tb/tb_jelly_fixed_float_mul_add2_arbiter.sv
// Bench for the mul_add2 arbiter: a queue-based stand-in for the shared unit plus a
// transaction-level reference of round-robin, locking, in-flight caps and return routing.
module tb_jelly_fixed_float_mul_add2_arbiter;
    localparam int unsigned NUM = 3, IDW = 2, UB = 4, FXW = 12, FLW = 32, EW = 8, MW = 48;
    localparam int unsigned MAXO = 4, LAT = 3;

    typedef struct { logic [UB-1:0] user; logic [FXW-1:0] x, y; logic [FLW-1:0] a, b, c; } req_t;
    typedef struct { int id; logic [UB-1:0] user; logic [EW-1:0] e; logic [MW-1:0] f; int age; } ret_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    jelly_fixed_float_mul_add2_arbiter_if #(.NUM(NUM), .ID_WIDTH(IDW), .USER_WIDTH(UB),
        .S_FIXED_WIDTH(FXW), .S_FLOAT_WIDTH(FLW), .M_DENORM_EXP_WIDTH(EW),
        .M_DENORM_FIXED_WIDTH(MW)) bus ();

    jelly_fixed_float_mul_add2_arbiter #(.NUM(NUM), .ID_WIDTH(IDW), .USER_WIDTH(UB),
        .S_FIXED_WIDTH(FXW), .S_FLOAT_WIDTH(FLW), .M_DENORM_EXP_WIDTH(EW),
        .M_DENORM_FIXED_WIDTH(MW), .MAX_OUTSTANDING(MAXO)) dut (
        .clk(clk), .reset_n(reset_n), .bus(bus));

    req_t           req [NUM];
    logic [NUM-1:0] rv, mr, stream;
    logic           usr, ret_en;
    bit             rnd_mode;
    ret_t           q [$];
    int             order [$];
    int             rr, locked, lock_id, both_evt, total, bad;
    int             cnt [NUM];
    int             issued [NUM];
    int             returned [NUM];
    logic [NUM-1:0] snap_sready;
    logic [127:0]   snap_pay;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic req_t new_req();
        req_t r;
        r.user = UB'($urandom); r.x = FXW'($urandom); r.y = FXW'($urandom);
        r.a = $urandom; r.b = $urandom; r.c = $urandom;
        return r;
    endfunction

    function automatic logic [125:0] pay_of(input int p);
        return {IDW'(p), req[p].user, req[p].x, req[p].y, req[p].a, req[p].b, req[p].c};
    endfunction

    task automatic clear_counts();
        for (int i = 0; i < NUM; i++) begin issued[i] = 0; returned[i] = 0; end
        order.delete(); both_evt = 0;
    endtask

    task automatic drive();
        for (int i = 0; i < NUM; i++) begin
            bus.s_valid[i] = rv[i];
            bus.s_user[i*UB +: UB] = req[i].user;
            bus.s_fixed_x[i*FXW +: FXW] = req[i].x;
            bus.s_fixed_y[i*FXW +: FXW] = req[i].y;
            bus.s_float_a[i*FLW +: FLW] = req[i].a;
            bus.s_float_b[i*FLW +: FLW] = req[i].b;
            bus.s_float_c[i*FLW +: FLW] = req[i].c;
        end
        bus.m_ready = mr;
        bus.unit_s_ready = usr;
        if (q.size() > 0 && q[0].age >= LAT && ret_en) begin
            bus.unit_m_valid = 1'b1;
            bus.unit_m_user = {IDW'(q[0].id), q[0].user};
            bus.unit_m_denorm_exp = q[0].e;
            bus.unit_m_denorm_fixed = q[0].f;
        end else begin
            bus.unit_m_valid = 1'b0;
            bus.unit_m_user = '0;
            bus.unit_m_denorm_exp = '0;
            bus.unit_m_denorm_fixed = '0;
        end
    endtask

    // One clock: drive at negedge, check against the reference, then advance it.
    task automatic tick();
        int g, rid, rid2;
        bit v, iss, hv, ret;
        logic exp_umr;
        logic [NUM-1:0] exp_sr, exp_mv;
        ret_t e;
        if (rnd_mode) begin
            for (int i = 0; i < NUM; i++)
                if (!rv[i] && $urandom_range(1, 0) == 1) begin rv[i] = 1'b1; req[i] = new_req(); end
            mr = NUM'($urandom);
            usr = ($urandom_range(3, 0) != 0);
            ret_en = ($urandom_range(4, 0) != 0);
        end
        for (int i = 0; i < NUM; i++)
            if (stream[i] && !rv[i]) begin rv[i] = 1'b1; req[i] = new_req(); end
        drive();
        #1;
        v = 0; g = 0;
        if (locked != 0) begin v = 1; g = lock_id; end
        else for (int k = 0; k < NUM; k++) begin
            int p;
            p = (rr + k) % NUM;
            if (!v && rv[p] && cnt[p] != MAXO) begin v = 1; g = p; end
        end
        iss = v && usr;
        exp_sr = iss ? (NUM'(1) << g) : '0;
        snap_sready = bus.s_ready;
        snap_pay = {bus.unit_s_user, bus.unit_s_fixed_x, bus.unit_s_fixed_y,
                    bus.unit_s_float_a, bus.unit_s_float_b, bus.unit_s_float_c};
        chk("unit_s_valid", bus.unit_s_valid, v);
        chk("s_ready", bus.s_ready, exp_sr);
        if (v) chk("unit_s_payload", snap_pay, pay_of(g));
        hv = bus.unit_m_valid;
        rid = 0;
        if (hv) rid = q[0].id;
        rid2 = (rid + 1) % NUM;
        exp_umr = mr[rid];
        ret = hv && exp_umr;
        exp_mv = hv ? (NUM'(1) << rid) : '0;
        chk("m_valid", bus.m_valid, exp_mv);
        chk("unit_m_ready", bus.unit_m_ready, exp_umr);
        if (hv) chk("m_data", {bus.m_user[rid*UB +: UB], bus.m_user[rid2*UB +: UB],
                              bus.m_denorm_exp[rid*EW +: EW], bus.m_denorm_exp[rid2*EW +: EW],
                              bus.m_denorm_fixed[rid*MW +: MW], bus.m_denorm_fixed[rid2*MW +: MW]},
                             {q[0].user, q[0].user, q[0].e, q[0].e, q[0].f, q[0].f});
        if (iss) begin
            e.id = g; e.user = req[g].user; e.e = EW'($urandom);
            e.f = {16'($urandom), $urandom}; e.age = 0;
            q.push_back(e);
            cnt[g]++; rr = (g + 1) % NUM; locked = 0; rv[g] = 1'b0;
            issued[g]++; order.push_back(g);
        end else if (v) begin
            locked = 1; lock_id = g;
        end
        if (ret) begin cnt[rid]--; returned[rid]++; void'(q.pop_front()); end
        if (iss && ret && g == rid) both_evt++;
        @(posedge clk);
        @(negedge clk);
        foreach (q[j]) q[j].age++;
    endtask

    // Asynchronous reset in mid-cycle: outputs must drop before any clock edge.
    task automatic reset_check();
        drive();
        #2 reset_n = 1'b0;
        #1;
        chk("rst_s_ready", bus.s_ready, '0);
        chk("rst_unit_s_valid", bus.unit_s_valid, 1'b0);
        chk("rst_m_valid", bus.m_valid, '0);
        chk("rst_unit_m_ready", bus.unit_m_ready, 1'b0);
        rr = 0; locked = 0; lock_id = 0; q.delete();
        for (int i = 0; i < NUM; i++) cnt[i] = 0;
        @(negedge clk);
        reset_n = 1'b1;
    endtask

    task automatic drain();
        rnd_mode = 0; stream = '0; mr = '1; usr = 1'b1; ret_en = 1'b1;
        for (int n = 0; n < 100 && (rv != '0 || q.size() != 0); n++) tick();
        chk("drain", {rv, 32'(q.size())}, '0);
    endtask

    initial begin
        int s0, s1, viol;
        total = 0; bad = 0; rnd_mode = 0; stream = '0;
        for (int i = 0; i < NUM; i++) begin req[i] = new_req(); cnt[i] = 0; end
        rv = '1; mr = '1; usr = 1'b1; ret_en = 1'b1; rr = 0; locked = 0; lock_id = 0;
        clear_counts();
        reset_check();

        // Stall lock: ports 0 and 2 wait while the unit is not ready.
        rv = 3'b101; req[0] = new_req(); req[2] = new_req(); usr = 1'b0;
        for (int n = 0; n < 5; n++) begin tick(); chk("lock_hold_p0", snap_pay, pay_of(0)); end
        usr = 1'b1;
        tick(); chk("lock_release_p0", snap_sready, 3'b001);
        tick(); chk("lock_next_p2", snap_sready, 3'b100);
        drain();

        // Single port 1: a=1.0 x=2 b=0.5 y=4 c=3.0.
        clear_counts();
        req[1].user = 4'h5; req[1].x = 12'd2; req[1].y = 12'd4;
        req[1].a = 32'h3f800000; req[1].b = 32'h3f000000; req[1].c = 32'h40400000;
        rv = 3'b010;
        tick(); chk("single_same_cycle", snap_sready, 3'b010);
        for (int n = 0; n < 8; n++) tick();
        chk("single_one_return", returned[1], 1);
        chk("single_other_ports", returned[0] + returned[2], 0);

        // Continuous requests on all ports: strict rotation, equal share.
        clear_counts(); stream = '1;
        for (int n = 0; n < 30; n++) tick();
        viol = 0;
        for (int k = 1; k < order.size(); k++) if (order[k] != (order[k-1] + 1) % NUM) viol++;
        chk("rr_rotation", viol, 0);
        for (int i = 0; i < NUM; i++) chk("rr_share", issued[i], 10);
        drain();

        // Outstanding limit on port 0 while its results are back-pressured.
        clear_counts(); stream = 3'b011; mr = 3'b110;
        for (int n = 0; n < 16; n++) tick();
        chk("limit_p0_accepts", issued[0], MAXO);
        chk("limit_p1_served", issued[1] >= MAXO, 1'b1);
        s0 = issued[0]; both_evt = 0;
        stream = 3'b001; mr = '1;
        for (int n = 0; n < 20; n++) tick();
        chk("limit_p0_resumes", issued[0] > s0, 1'b1);
        chk("limit_same_cycle_ret_issue", both_evt > 0, 1'b1);
        drain();

        // Return back-pressure on port 2.
        clear_counts(); rv = 3'b100; req[2] = new_req(); mr = 3'b011;
        for (int n = 0; n < 8; n++) tick();
        chk("bp_held_m_valid", bus.m_valid, 3'b100);
        chk("bp_unit_m_ready", bus.unit_m_ready, 1'b0);
        chk("bp_not_returned", returned[2], 0);
        mr = '1;
        tick(); chk("bp_completed", returned[2], 1);
        drain();

        // Reset with port 1 locked and three of its requests in flight.
        clear_counts(); ret_en = 1'b0; stream = 3'b010;
        for (int n = 0; n < 20 && issued[1] < 3; n++) tick();
        chk("pre_reset_cnt", issued[1], 3);
        stream = '0; rv[1] = 1'b1; req[1] = new_req(); usr = 1'b0;
        tick();
        ret_en = 1'b1; usr = 1'b1;
        reset_check();
        clear_counts(); rv[2] = 1'b1; req[2] = new_req();
        tick(); chk("post_reset_first_grant", snap_sready, 3'b010);
        ret_en = 1'b0; stream = 3'b010;
        for (int n = 0; n < 14; n++) tick();
        chk("post_reset_cnt_cleared", issued[1], MAXO);
        drain();

        // Random traffic against the reference.
        clear_counts(); rnd_mode = 1;
        for (int n = 0; n < 400; n++) tick();
        drain();
        s0 = 0; s1 = 0;
        for (int i = 0; i < NUM; i++) begin s0 += issued[i]; s1 += returned[i]; end
        chk("random_all_returned", s1, s0);
        chk("random_traffic_seen", s0 > 50, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
